// File: rtl/sample_ram_responder.sv
// Two-port Avalon-MM responder in front of one single-port sample RAM.
// Round-robin arbitration, two-stage tagged read pipeline.
module sample_ram_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter logic [31:0] BASE   = 32'h0
) (
   input  logic        csi_clk,
   input  logic        rsi_reset_n,
   input  logic        avs_s1_read,
   input  logic        avs_s1_write,
   input  logic [31:0] avs_s1_address,
   input  logic [31:0] avs_s1_writedata,
   output logic        avs_s1_waitrequest,
   output logic [31:0] avs_s1_readdata,
   output logic        avs_s1_readdatavalid,
   input  logic        avs_s2_read,
   input  logic        avs_s2_write,
   input  logic [31:0] avs_s2_address,
   input  logic [31:0] avs_s2_writedata,
   output logic        avs_s2_waitrequest,
   output logic [31:0] avs_s2_readdata,
   output logic        avs_s2_readdatavalid
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic              req1, req2;
   logic              gnt1, gnt2;
   logic              prefer2;
   logic              acc, sel_wr, sel_rd;
   logic [31:0]       sel_addr, sel_wdata;
   logic [ADDR_W-1:0] idx;
   logic              in_range;
   logic              unused_bits;

   logic              a_vld, a_tag, a_hit;
   logic [31:0]       ram_q;
   logic [31:0]       data_b;

   assign req1 = avs_s1_read | avs_s1_write;
   assign req2 = avs_s2_read | avs_s2_write;

   // No grants while reset is held, so nothing reaches the RAM then.
   always_comb begin
      gnt1 = 1'b0;
      gnt2 = 1'b0;
      if (rsi_reset_n) begin
         if (req1 && req2) begin
            gnt1 = ~prefer2;
            gnt2 = prefer2;
         end else begin
            gnt1 = req1;
            gnt2 = req2;
         end
      end
   end

   assign avs_s1_waitrequest = ~rsi_reset_n | (req1 & ~gnt1);
   assign avs_s2_waitrequest = ~rsi_reset_n | (req2 & ~gnt2);

   assign acc       = gnt1 | gnt2;
   assign sel_wr    = gnt1 ? avs_s1_write     : avs_s2_write;
   assign sel_addr  = gnt1 ? avs_s1_address   : avs_s2_address;
   assign sel_wdata = gnt1 ? avs_s1_writedata : avs_s2_writedata;
   assign sel_rd    = acc & ~sel_wr;

   assign idx      = sel_addr[ADDR_W+1:2];
   assign in_range = sel_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2];
   assign unused_bits = ^sel_addr[1:0];

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         prefer2 <= 1'b0;
      end else if (gnt1) begin
         prefer2 <= 1'b1;
      end else if (gnt2) begin
         prefer2 <= 1'b0;
      end
   end

   always_ff @(posedge csi_clk) begin
      if (acc && sel_wr && in_range) begin
         mem[idx] <= sel_wdata;
      end
   end

   always_ff @(posedge csi_clk) begin
      if (sel_rd) begin
         ram_q <= mem[idx];
      end
   end

   // Stage A carries the port tag and range hit alongside the RAM output.
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         a_vld <= 1'b0;
         a_tag <= 1'b0;
         a_hit <= 1'b0;
      end else begin
         a_vld <= sel_rd;
         a_tag <= gnt2;
         a_hit <= in_range;
      end
   end

   assign data_b = a_hit ? ram_q : 32'h0;

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         avs_s1_readdatavalid <= 1'b0;
         avs_s2_readdatavalid <= 1'b0;
         avs_s1_readdata      <= 32'h0;
         avs_s2_readdata      <= 32'h0;
      end else begin
         avs_s1_readdatavalid <= a_vld & ~a_tag;
         avs_s2_readdatavalid <= a_vld & a_tag;
         if (a_vld && !a_tag) begin
            avs_s1_readdata <= data_b;
         end
         if (a_vld && a_tag) begin
            avs_s2_readdata <= data_b;
         end
      end
   end

endmodule

// File: tb/tb_sample_ram_responder.sv
// Bench for sample_ram_responder: vector table, directed corners,
// randomized two-master traffic against a cycle-level reference model.
module tb_sample_ram_responder;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        rd, wr, wq, rdv;
   logic [1:0][31:0]  addr, wd, rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sample_ram_responder #(.ADDR_W(10), .BASE(32'h0)) dut (
      .csi_clk              (clk),
      .rsi_reset_n          (rst_n),
      .avs_s1_read          (rd[0]),
      .avs_s1_write         (wr[0]),
      .avs_s1_address       (addr[0]),
      .avs_s1_writedata     (wd[0]),
      .avs_s1_waitrequest   (wq[0]),
      .avs_s1_readdata      (rdata[0]),
      .avs_s1_readdatavalid (rdv[0]),
      .avs_s2_read          (rd[1]),
      .avs_s2_write         (wr[1]),
      .avs_s2_address       (addr[1]),
      .avs_s2_writedata     (wd[1]),
      .avs_s2_waitrequest   (wq[1]),
      .avs_s2_readdata      (rdata[1]),
      .avs_s2_readdatavalid (rdv[1])
   );

   typedef struct {
      bit          w;
      int          p;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [31:0] d;
   } rsp_t;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(int p, bit r, bit w, logic [31:0] a, logic [31:0] d);
      rd[p]   = r;
      wr[p]   = w;
      addr[p] = a;
      wd[p]   = d;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0);
   endtask

   task automatic rst_pulse();
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Solo access on one port; reads check the exact two-cycle latency.
   task automatic acc(int p, bit w, logic [31:0] a, logic [31:0] d,
                      logic [31:0] exp, string nm);
      tick();
      drv(p, !w, w, a, d);
      #1;
      chk({nm, " wait"}, 32'(wq[p]), 0);
      tick();
      drv(p, 0, 0, 0, 0);
      if (!w) begin
         #1;
         chk({nm, " early"}, 32'(rdv[p]), 0);
         tick();
         #1;
         chk({nm, " valid"}, 32'(rdv[p]), 1);
         chk({nm, " data"}, rdata[p], exp);
      end
   endtask

   vec_t        tbl[$];
   logic [31:0] mdl [1024];
   rsp_t        q0[$], q1[$];
   logic [31:0] last_rd [2];
   bit          act [2];
   int          last_g;

   function automatic bit in_rng(logic [31:0] a);
      return a < 32'h1000;
   endfunction

   initial begin
      idle();
      #3;
      chk("rst wq1", 32'(wq[0]), 1);
      chk("rst wq2", 32'(wq[1]), 1);
      chk("rst rdv1", 32'(rdv[0]), 0);
      chk("rst rdv2", 32'(rdv[1]), 0);
      chk("rst rdata1", rdata[0], 0);
      chk("rst rdata2", rdata[1], 0);
      tick();
      tick();
      rst_n = 1'b1;

      // Vector table: {write, port, addr, wdata, expected read data}
      tbl.push_back('{1, 0, 32'h0000_0000, 32'h1111_1111, 32'h0});
      tbl.push_back('{1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0});
      tbl.push_back('{0, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF});
      tbl.push_back('{0, 0, 32'h0000_1000, 32'h0, 32'h0});
      tbl.push_back('{1, 0, 32'h0000_1000, 32'hBAD0_BAD0, 32'h0});
      tbl.push_back('{0, 0, 32'h0000_0000, 32'h0, 32'h1111_1111});
      tbl.push_back('{1, 1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0});
      tbl.push_back('{0, 0, 32'h0000_0011, 32'h0, 32'hCAFE_F00D});
      tbl.push_back('{1, 1, 32'h0000_0FFC, 32'h5A5A_5A5A, 32'h0});
      tbl.push_back('{0, 1, 32'h0000_0FFE, 32'h0, 32'h5A5A_5A5A});
      tbl.push_back('{0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0});
      tbl.push_back('{0, 1, 32'h0000_0000, 32'h0, 32'h1111_1111});
      foreach (tbl[i])
         acc(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp,
             $sformatf("vec%0d", i));

      // Tie after reset: s1 first, s2 one cycle later; RAM survives reset
      rst_pulse();
      tick();
      drv(0, 1, 0, 32'h0, 0);
      drv(1, 1, 0, 32'h10, 0);
      #1;
      chk("tie1 wq1", 32'(wq[0]), 0);
      chk("tie1 wq2", 32'(wq[1]), 1);
      tick();
      drv(0, 0, 0, 0, 0);
      #1;
      chk("tie1 wq2 next", 32'(wq[1]), 0);
      chk("tie1 rdv1 T+1", 32'(rdv[0]), 0);
      tick();
      drv(1, 0, 0, 0, 0);
      #1;
      chk("tie1 rdv1", 32'(rdv[0]), 1);
      chk("tie1 data1", rdata[0], 32'h1111_1111);
      chk("tie1 rdv2 T+2", 32'(rdv[1]), 0);
      tick();
      #1;
      chk("tie1 rdv2", 32'(rdv[1]), 1);
      chk("tie1 data2", rdata[1], 32'hCAFE_F00D);
      chk("tie1 rdv1 off", 32'(rdv[0]), 0);

      // s1 granted alone, so the next tie goes to s2
      acc(0, 0, 32'h0, 0, 32'h1111_1111, "solo1");
      tick();
      drv(0, 1, 0, 32'h0, 0);
      drv(1, 1, 0, 32'h10, 0);
      #1;
      chk("tie2 wq1", 32'(wq[0]), 1);
      chk("tie2 wq2", 32'(wq[1]), 0);
      tick();
      drv(1, 0, 0, 0, 0);
      #1;
      chk("tie2 wq1 next", 32'(wq[0]), 0);
      tick();
      drv(0, 0, 0, 0, 0);
      #1;
      chk("tie2 rdv2", 32'(rdv[1]), 1);
      chk("tie2 data2", rdata[1], 32'hCAFE_F00D);
      tick();
      #1;
      chk("tie2 rdv1", 32'(rdv[0]), 1);
      chk("tie2 data1", rdata[0], 32'h1111_1111);

      // Cross-port: s2 write wins the tie, s1 read then sees it
      acc(0, 0, 32'h10, 0, 32'hCAFE_F00D, "solo2");
      tick();
      drv(0, 1, 0, 32'h40, 0);
      drv(1, 0, 1, 32'h40, 32'h1234);
      #1;
      chk("xw wq1", 32'(wq[0]), 1);
      chk("xw wq2", 32'(wq[1]), 0);
      tick();
      drv(1, 0, 0, 0, 0);
      #1;
      chk("xw wq1 next", 32'(wq[0]), 0);
      tick();
      drv(0, 0, 0, 0, 0);
      #1;
      chk("xw rdv1 T+1", 32'(rdv[0]), 0);
      tick();
      #1;
      chk("xw rdv1", 32'(rdv[0]), 1);
      chk("xw data1", rdata[0], 32'h1234);

      // Streaming: 8 writes on s2, 8 back-to-back reads on s1
      for (int i = 0; i < 8; i++) begin
         tick();
         drv(1, 0, 1, 32'(4 * i), 32'(i));
         #1;
         chk($sformatf("strw%0d wq", i), 32'(wq[1]), 0);
      end
      tick();
      drv(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         drv(0, 1, 0, 32'(4 * i), 0);
         #1;
         chk($sformatf("strr%0d wq", i), 32'(wq[0]), 0);
         chk($sformatf("strr%0d rdv", i), 32'(rdv[0]), (i >= 2) ? 1 : 0);
         if (i >= 2)
            chk($sformatf("strr%0d data", i), rdata[0], 32'(i - 2));
      end
      tick();
      drv(0, 0, 0, 0, 0);
      #1;
      chk("str rdv 6", 32'(rdv[0]), 1);
      chk("str data 6", rdata[0], 32'd6);
      tick();
      #1;
      chk("str rdv 7", 32'(rdv[0]), 1);
      chk("str data 7", rdata[0], 32'd7);
      tick();
      #1;
      chk("str rdv end", 32'(rdv[0]), 0);
      chk("str hold", rdata[0], 32'd7);

      // Reset in T+1 kills the in-flight read
      tick();
      drv(0, 1, 0, 32'h4, 0);
      #1;
      chk("mid wq", 32'(wq[0]), 0);
      tick();
      drv(0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid rst wq1", 32'(wq[0]), 1);
      chk("mid rst wq2", 32'(wq[1]), 1);
      chk("mid rst rdv1", 32'(rdv[0]), 0);
      chk("mid rst rdata1", rdata[0], 0);
      tick();
      #1;
      chk("mid rst2 rdv1", 32'(rdv[0]), 0);
      chk("mid rst2 rdata2", rdata[1], 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk($sformatf("post rst rdv1 %0d", i), 32'(rdv[0]), 0);
         chk($sformatf("post rst rdv2 %0d", i), 32'(rdv[1]), 0);
      end

      // Randomized traffic against the reference model
      rst_pulse();
      for (int w = 0; w < 32; w++) begin
         mdl[w] = $urandom;
         acc(0, 1, 32'(4 * w), mdl[w], 0, "init");
      end
      last_g = 0;
      last_rd[0] = 0;
      last_rd[1] = 0;
      act[0] = 0;
      act[1] = 0;
      for (int c = 0; c < 1500; c++) begin
         int g;
         tick();
         for (int p = 0; p < 2; p++) begin
            if (!act[p] && c < 1490 && $urandom_range(0, 9) < 6) begin
               bit          w;
               bit          r;
               logic [31:0] a;
               w = $urandom_range(0, 9) < 4;
               r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
               if ($urandom_range(0, 7) == 0)
                  a = $urandom | 32'h1000;
               else
                  a = 32'(4 * $urandom_range(0, 31) + $urandom_range(0, 3));
               drv(p, r, w, a, $urandom);
               act[p] = 1;
            end else if (!act[p]) begin
               drv(p, 0, 0, $urandom, $urandom);
            end
         end
         #1;
         if (q0.size() > 0 && q0[0].cyc == c) begin
            last_rd[0] = q0[0].d;
            chk("rnd rdv1", 32'(rdv[0]), 1);
            void'(q0.pop_front());
         end else begin
            chk("rnd rdv1", 32'(rdv[0]), 0);
         end
         if (q1.size() > 0 && q1[0].cyc == c) begin
            last_rd[1] = q1[0].d;
            chk("rnd rdv2", 32'(rdv[1]), 1);
            void'(q1.pop_front());
         end else begin
            chk("rnd rdv2", 32'(rdv[1]), 0);
         end
         chk("rnd rdata1", rdata[0], last_rd[0]);
         chk("rnd rdata2", rdata[1], last_rd[1]);
         g = -1;
         if (act[0] && act[1])
            g = (last_g == 0) ? 1 : 0;
         else if (act[0])
            g = 0;
         else if (act[1])
            g = 1;
         chk("rnd wq1", 32'(wq[0]), (act[0] && g != 0) ? 1 : 0);
         chk("rnd wq2", 32'(wq[1]), (act[1] && g != 1) ? 1 : 0);
         if (g >= 0) begin
            if (wr[g]) begin
               if (in_rng(addr[g]))
                  mdl[addr[g][11:2]] = wd[g];
            end else begin
               rsp_t r;
               r.cyc = c + 2;
               r.d   = in_rng(addr[g]) ? mdl[addr[g][11:2]] : 32'h0;
               if (g == 0) q0.push_back(r);
               else        q1.push_back(r);
            end
            last_g = g;
            act[g] = 0;
         end
      end
      chk("rnd drained1", 32'(q0.size()), 0);
      chk("rnd drained2", 32'(q1.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
